r_rom_backend: RTL and testbench



---
 rtl/r_rom_pkg.sv | 20 ++
 rtl/r_rom_backend_byte_shifter.sv | 55 +++++
 rtl/r_rom_backend.sv | 172 +++++++++++++++++
 tb/tb_r_rom_backend.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/r_rom_pkg.sv
// Shared definitions for the r_rom FT-side backend.
// Holds the backend state encoding, default byte counts for address and data,
// and the ENABLE/DISABLE constants used to tie off unused control inputs.
package r_rom_pkg;

  // Backend sequencing: gather address bytes, request, wait for data, drain.
  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int DEFAULT_ADDR_BYTES = 8;
  localparam int DEFAULT_DATA_BYTES = 8;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/r_rom_backend_byte_shifter.sv
// byte_shifter: N-byte register that shifts right by one byte per shift_i,
// inserting byte_i at the top. Used both to assemble an address from
// LSB-first command bytes and to serialise read data LSB-first.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears the register)
//   clr_i        - synchronous clear, highest priority after reset
//   load_i       - parallel load of load_data_i
//   load_data_i  - parallel load value
//   shift_i      - shift right by 8, byte_i enters at the top
//   byte_i       - byte inserted on shift
//   value_o      - full register contents
//   byte_o       - lowest byte (next byte to be shifted out)
module byte_shifter
  import r_rom_pkg::*;
#(
  parameter int N = DEFAULT_ADDR_BYTES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           load_i,
  input  logic [8*N-1:0] load_data_i,
  input  logic           shift_i,
  input  logic [7:0]     byte_i,
  output logic [8*N-1:0] value_o,
  output logic [7:0]     byte_o
);

  logic [8*N-1:0] sh_q, sh_d;

  // Next contents: clear beats load, load beats shift; otherwise hold.
  always_comb begin
    sh_d = sh_q;
    if (clr_i) begin
      sh_d = '0;
    end else if (load_i) begin
      sh_d = load_data_i;
    end else if (shift_i) begin
      sh_d = {byte_i, sh_q[8*N-1:8]};
    end
  end

  // Register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign value_o = sh_q;
  assign byte_o  = sh_q[7:0];

endmodule

// File: rtl/r_rom_backend.sv
// r_rom_backend: FT-side engine between the r_rom command/response byte FIFOs
// and a req/gnt/rvalid memory port. Pops ADDR_BYTES address bytes (LSB first),
// issues one read, and pushes DATA_BYTES response bytes (LSB first).
// Ports:
//   clk, rst            - FT clock, synchronous active-high reset
//   c_empty/c_rd_en     - command FIFO empty flag / pop
//   c_dout              - command byte, valid the cycle after a pop
//   r_full/r_wr_en/r_din- response FIFO full flag / push / data
//   mem_req/mem_addr    - read request and its address (stable while req)
//   mem_gnt             - request accepted
//   mem_rvalid/mem_rdata- read data return
//   busy                - low only when idle in S_CMD with nothing captured
module r_rom_backend
  import r_rom_pkg::*;
#(
  parameter int ADDR_BYTES = DEFAULT_ADDR_BYTES,
  parameter int DATA_BYTES = DEFAULT_DATA_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    c_empty,
  output logic                    c_rd_en,
  input  logic [7:0]              c_dout,
  input  logic                    r_full,
  output logic                    r_wr_en,
  output logic [7:0]              r_din,
  output logic                    mem_req,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    busy
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int ACW = $clog2(ADDR_BYTES) + 1;
  localparam int DCW = $clog2(DATA_BYTES) + 1;

  localparam logic [ACW-1:0] ADDR_CNT_MAX  = ACW'(ADDR_BYTES);
  localparam logic [ACW-1:0] ADDR_CNT_LAST = ACW'(ADDR_BYTES - 1);
  localparam logic [DCW-1:0] DATA_CNT_LAST = DCW'(DATA_BYTES - 1);

  state_e         state_q, state_d;
  logic [ACW-1:0] req_cnt_q, req_cnt_d;
  logic [ACW-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [DCW-1:0] out_cnt_q, out_cnt_d;
  logic           pop_q;

  logic           addr_shift;
  logic           addr_clr;
  logic           data_load;
  logic           data_shift;
  logic [7:0]     data_byte;
  logic [7:0]     unused_addr_byte;
  logic [DW-1:0]  unused_data_val;

  // The address register doubles as mem_addr: it only moves in S_CMD, so it
  // is stable for the whole request, and it is cleared when a read finishes.
  byte_shifter #(.N(ADDR_BYTES)) u_addr_sh (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (addr_clr),
    .load_i      (DISABLE),
    .load_data_i ('0),
    .shift_i     (addr_shift),
    .byte_i      (c_dout),
    .value_o     (mem_addr),
    .byte_o      (unused_addr_byte)
  );

  // Read data is loaded whole and then drained one byte at a time.
  byte_shifter #(.N(DATA_BYTES)) u_data_sh (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (DISABLE),
    .load_i      (data_load),
    .load_data_i (mem_rdata),
    .shift_i     (data_shift),
    .byte_i      (8'h00),
    .value_o     (unused_data_val),
    .byte_o      (data_byte)
  );

  // Next-state and output decode. Pops, pushes and requests are all
  // suppressed while rst is high so a reset never disturbs FIFO contents.
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    out_cnt_d  = out_cnt_q;
    c_rd_en    = DISABLE;
    r_wr_en    = DISABLE;
    r_din      = 8'h00;
    mem_req    = DISABLE;
    addr_shift = DISABLE;
    addr_clr   = DISABLE;
    data_load  = DISABLE;
    data_shift = DISABLE;
    if (!rst) begin
      unique case (state_q)
        S_CMD: begin
          // req_cnt caps pops at ADDR_BYTES even if the FIFO stays non-empty.
          if (!c_empty && (req_cnt_q != ADDR_CNT_MAX)) begin
            c_rd_en   = ENABLE;
            req_cnt_d = req_cnt_q + ACW'(1);
          end
          // pop_q marks c_dout valid this cycle.
          if (pop_q) begin
            addr_shift = ENABLE;
            rcv_cnt_d  = rcv_cnt_q + ACW'(1);
            if (rcv_cnt_q == ADDR_CNT_LAST) begin
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          mem_req = ENABLE;
          if (mem_gnt) begin
            if (mem_rvalid) begin
              data_load = ENABLE;
              state_d   = S_RESP;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            data_load = ENABLE;
            state_d   = S_RESP;
          end
        end
        S_RESP: begin
          if (!r_full) begin
            r_wr_en    = ENABLE;
            r_din      = data_byte;
            data_shift = ENABLE;
            out_cnt_d  = out_cnt_q + DCW'(1);
            if (out_cnt_q == DATA_CNT_LAST) begin
              state_d   = S_CMD;
              req_cnt_d = '0;
              rcv_cnt_d = '0;
              out_cnt_d = '0;
              addr_clr  = ENABLE;
            end
          end
        end
        default: state_d = S_CMD;
      endcase
    end
  end

  // State, counters and the pop-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CMD;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      out_cnt_q <= '0;
      pop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      out_cnt_q <= out_cnt_d;
      pop_q     <= c_rd_en;
    end
  end

  assign busy = ~((state_q == S_CMD) && (rcv_cnt_q == '0));

endmodule

// File: tb/tb_r_rom_backend.sv
// Testbench for r_rom_backend. Command FIFO, memory and response FIFO are
// modelled in the bench; expected addresses and response bytes are derived
// from the transactions queued by applyStimulus.
module tb_r_rom_backend;

  localparam int AB = 8;
  localparam int DB = 8;

  typedef struct {
    int          gntDelay;
    int          rvDelay;
    logic [63:0] data;
  } memCfg_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_empty;
  logic          c_rd_en;
  logic [7:0]    c_dout;
  logic          r_full;
  logic          r_wr_en;
  logic [7:0]    r_din;
  logic          mem_req;
  logic [8*AB-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [8*DB-1:0] mem_rdata;
  logic          busy;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0]  cmdQ[$];
  logic [63:0] expAddrQ[$];
  logic [7:0]  expRespQ[$];
  memCfg_t     cfgQ[$];
  memCfg_t     curCfg;

  bit          popPending   = 0;
  bit          reqActive    = 0;
  logic [63:0] reqAddr      = '0;
  int          gntWait      = 0;
  int          rvCnt        = 0;
  int          popsSinceReq = 0;
  int          pushesInTxn  = 0;
  int          fullHold     = 0;
  bit          fullAfter3   = 0;
  bit          sparseMode   = 0;
  bit          sparseToggle = 0;
  int          emptyProb    = 0;
  int          fullProb     = 0;

  always #5 clk = ~clk;

  r_rom_backend #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .c_empty    (c_empty),
    .c_rd_en    (c_rd_en),
    .c_dout     (c_dout),
    .r_full     (r_full),
    .r_wr_en    (r_wr_en),
    .r_din      (r_din),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Queue one read: address bytes go to the command FIFO LSB first, and the
  // memory will answer with data, whose bytes must come back LSB first.
  task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data,
                               input int gntDelay, input int rvDelay);
    memCfg_t c;
    for (int i = 0; i < AB; i++) cmdQ.push_back(addr[8*i +: 8]);
    for (int i = 0; i < DB; i++) expRespQ.push_back(data[8*i +: 8]);
    expAddrQ.push_back(addr);
    c.gntDelay = gntDelay;
    c.rvDelay  = rvDelay;
    c.data     = data;
    cfgQ.push_back(c);
  endtask

  // One clock of the environment: apply the effect of the last edge, drive
  // the next inputs, then observe the combinational outputs.
  task automatic stepCycle();
    @(negedge clk);
    if (popPending) begin
      if (cmdQ.size() > 0) c_dout = cmdQ.pop_front();
      popPending = 0;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    if (rvCnt > 0) begin
      rvCnt--;
      if (rvCnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = curCfg.data;
      end
    end
    if (mem_req) begin
      if (!reqActive) begin
        reqActive = 1;
        reqAddr   = mem_addr;
        checkOutput("popsPerTxn", popsSinceReq, AB);
        checkOutput("busyInReq", busy, 1);
        popsSinceReq = 0;
        if (expAddrQ.size() == 0) begin
          checkOutput("extraReq", mem_req, 0);
          curCfg.gntDelay = 0; curCfg.rvDelay = 0; curCfg.data = '0;
        end else begin
          checkOutput("memAddr", mem_addr, expAddrQ.pop_front());
          curCfg = cfgQ.pop_front();
        end
        gntWait = curCfg.gntDelay;
      end else begin
        checkOutput("addrStable", mem_addr, reqAddr);
      end
      if (gntWait == 0) begin
        mem_gnt   = 1'b1;
        reqActive = 0;
        if (curCfg.rvDelay == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = curCfg.data;
        end else begin
          rvCnt = curCfg.rvDelay;
        end
      end else begin
        gntWait--;
      end
    end
    if (sparseMode) sparseToggle = ~sparseToggle;
    c_empty = (cmdQ.size() == 0) || (sparseMode && sparseToggle) ||
              ($urandom_range(99) < emptyProb);
    if (fullHold > 0) begin
      r_full = 1'b1;
      fullHold--;
    end else begin
      r_full = ($urandom_range(99) < fullProb);
    end
    #1;
    if (c_rd_en) begin
      checkOutput("popWhileEmpty", c_empty, 0);
      popPending = 1;
      popsSinceReq++;
    end
    if (r_wr_en) begin
      checkOutput("pushWhileFull", r_full, 0);
      if (expRespQ.size() == 0) checkOutput("extraPush", r_wr_en, 0);
      else checkOutput("respByte", r_din, expRespQ.pop_front());
      pushesInTxn++;
      if (fullAfter3 && pushesInTxn == 3) fullHold = 5;
      if (pushesInTxn == DB) pushesInTxn = 0;
    end
  endtask

  task automatic waitIdle(input int budget);
    int remaining;
    remaining = 1;
    while (remaining != 0 && budget > 0) begin
      stepCycle();
      budget--;
      remaining = cmdQ.size() + expRespQ.size() + expAddrQ.size() +
                  int'(reqActive) + rvCnt + int'(busy) + int'(popPending);
    end
    checkOutput("drain", remaining, 0);
    checkOutput("busyIdle", busy, 0);
  endtask

  task automatic checkResetState();
    checkOutput("rstCRdEn", c_rd_en, 0);
    checkOutput("rstRWrEn", r_wr_en, 0);
    checkOutput("rstRDin", r_din, 0);
    checkOutput("rstMemReq", mem_req, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstBusy", busy, 0);
  endtask

  initial begin
    int budget;
    rst = 1'b1; c_empty = 1'b1; c_dout = 8'h00; r_full = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) stepCycle();
    rst = 1'b0;
    #1;
    checkResetState();

    $display("[TB] basic read");
    applyStimulus(64'h0807060504030201, 64'h1122334455667788, 0, 1);
    waitIdle(200);

    $display("[TB] excess command bytes");
    applyStimulus(64'h1817161514131211, {$urandom, $urandom}, 0, 1);
    applyStimulus(64'h201F1E1D1C1B1A19, {$urandom, $urandom}, 0, 1);
    waitIdle(300);

    $display("[TB] response backpressure");
    fullAfter3 = 1;
    applyStimulus({$urandom, $urandom}, 64'hA1B2C3D4E5F60718, 0, 1);
    waitIdle(200);
    fullAfter3 = 0;

    $display("[TB] grant/valid timing");
    applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 4, 0);
    waitIdle(200);
    applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 0, 10);
    waitIdle(200);

    $display("[TB] sparse command stream");
    sparseMode = 1;
    applyStimulus(64'hCAFEBABE0BADF00D, {$urandom, $urandom}, 1, 2);
    waitIdle(300);
    sparseMode = 0;

    $display("[TB] reset mid-transaction");
    applyStimulus(64'hDEADBEEF01234567, {$urandom, $urandom}, 0, 200);
    budget = 200;
    while (!(rvCnt > 0 && rvCnt < 197) && budget > 0) begin
      stepCycle();
      budget--;
    end
    checkOutput("inWaitReq", mem_req, 0);
    checkOutput("inWaitBusy", busy, 1);
    rst = 1'b1;
    rvCnt = 0; reqActive = 0; popsSinceReq = 0; pushesInTxn = 0;
    expRespQ.delete();
    stepCycle();
    rst = 1'b0;
    #1;
    checkResetState();
    applyStimulus(64'h7766554433221100, 64'h0F1E2D3C4B5A6978, 2, 3);
    waitIdle(300);

    $display("[TB] randomized stream");
    emptyProb = 30;
    fullProb  = 30;
    for (int t = 0; t < 6; t++) begin
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(5)), int'($urandom_range(6)));
    end
    waitIdle(3000);
    emptyProb = 0;
    fullProb  = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
